sha_msg_ctrl: RTL and testbench
===============================

SHA_MSG_CTRL -- requirements
Module: sha_msg_ctrl

Interface
REQ-001 SHALL have parameter: WAIT_DONE, 1, when 1 hold after each block until core_done; when 0 go directly to the next block.
REQ-002 SHALL have port: clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: msg_valid  input  1  host beat valid.
REQ-005 SHALL have port: msg_ready  output  1  controller accepts beat.
REQ-006 SHALL have port: msg_data  input  32  message bytes, big-endian, first byte in [31:24].
REQ-007 SHALL have port: msg_bytes  input  3  valid bytes in beat, MSB-aligned, 0..4.
REQ-008 SHALL have port: msg_last  input  1  final beat of message.
REQ-009 SHALL have port: blk_valid  output  1  word to SHA core valid.
REQ-010 SHALL have port: blk_ready  input  1  SHA core accepts word.
REQ-011 SHALL have port: blk_word  output  32  schedule word W[t], t=0..15.
REQ-012 SHALL have port: blk_first  output  1  high with word 0 of the first block of a message (core reloads initial H).
REQ-013 SHALL have port: blk_last  output  1  high with word 15 of the final block of a message.
REQ-014 SHALL have port: core_done  input  1  one-cycle pulse, core finished compressing a block.
REQ-015 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port: err  output  1  sticky protocol error flag.

Function
REQ-017 SHALL implement states IDLE, FILL, PAD, XPAD, SEND, WAIT, with no other encodings reachable.
REQ-018 IDLE: msg_ready=1; the first valid beat clears the 64-bit bit counter, clears err and blk_first_pend, sets blk_first_pend=1, and is processed as a FILL beat.
REQ-019 FILL: msg_ready=1 and no state other than FILL/IDLE asserts msg_ready; a beat is accepted on msg_valid&&msg_ready.
REQ-020 An accepted beat SHALL be written to the buffer at byte offset wptr, advancing wptr by msg_bytes and adding msg_bytes*8 to the bit counter (modulo 2^64).
REQ-021 Legal beats: msg_bytes==4, or msg_bytes in 0..3 only with msg_last=1; any other beat SHALL set err, be dropped without changing counter or buffer, and leave the state unchanged.
REQ-022 A non-last beat that fills byte 63 SHALL cause the transition FILL->SEND.
REQ-023 A last beat SHALL cause the transition to PAD with n = bytes in the current block (0..64).
REQ-024 PAD with n<=55: write 0x80 at byte n, zeros through byte 55, bit counter big-endian in bytes 56..63, mark block final, then ->SEND.
REQ-025 PAD with 56<=n<=63: write 0x80 at byte n and zeros to byte 63, set xpad_pend, then ->SEND.
REQ-026 PAD with n==64: set xpad_pend with pad80_pend=1, then ->SEND.
REQ-027 XPAD: write zero block, with byte 0 = 0x80 if pad80_pend, and the counter in bytes 56..63; mark the block final, then ->SEND.
REQ-028 SEND: blk_valid=1 and blk_word=buffer word t; t advances on blk_valid&&blk_ready; blk_word, blk_first and blk_last SHALL stay stable while blk_ready=0.
REQ-029 blk_first=blk_first_pend && t==0; blk_first_pend SHALL clear when word 0 is accepted.
REQ-030 blk_last=final && t==15.
REQ-031 On acceptance of word 15: ->WAIT if WAIT_DONE=1, else next state directly.
REQ-032 WAIT: on core_done go to XPAD if xpad_pend, else IDLE if the block was final, else FILL with wptr=0.
REQ-033 core_done outside WAIT SHALL be ignored.
REQ-034 blk_valid SHALL assert the cycle after the block completes (FILL/PAD/XPAD exit), giving 1-cycle latency.
REQ-035 A beat SHALL never be accepted while a block is pending send; a single buffer is used.
REQ-036 The bit counter SHALL count message bits only, never padding.

Reset
REQ-037 While rst=0: state=IDLE, msg_ready=0, blk_valid=0, blk_word=0, blk_first=0, blk_last=0, busy=0, err=0, and wptr, t, counter, flags and buffer all 0.
REQ-038 msg_ready SHALL rise the first clk edge after rst deasserts.
REQ-039 Reset mid-message SHALL discard all state with no further blk_valid.

Structure
REQ-040 Package sha256_pkg SHALL hold the state enum, PAD_BYTE=8'h80, BLOCK_BYTES=64, BLOCK_WORDS=16 and LEN_OFFSET=56.
REQ-041 One sub-module sha_blk_buf SHALL hold the 64-byte register buffer, with byte-offset write of 0..4 bytes, clear, and 32-bit word read.

Verification
REQ-042 "abc" (one beat 0x61626300, bytes=3, last) -> one block W0=0x61626380, W1..W14=0, W15=0x00000018, blk_first at W0, blk_last at W15.
REQ-043 Empty message (bytes=0, last) -> W0=0x80000000, W1..W15=0, with first and last set.
REQ-044 56-byte message -> two blocks: block1 W14=0x80000000, W15=0; block2 W0..W13=0, W15=0x000001C0, blk_last only in block2.
REQ-045 64-byte message -> block1 is the data unpadded; block2 W0=0x80000000, W15=0x00000200.
REQ-046 blk_ready low 3 cycles at W5 -> blk_word stable and no word skipped; core_done pulsed in FILL -> ignored.
REQ-047 Beat bytes=2, last=0 -> err=1 and beat dropped; then reset asserted mid-SEND -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and constants for the SHA-256 message controller.
//   state_e     - controller FSM states
//   PAD_BYTE    - first padding byte appended after the message
//   BLOCK_BYTES - bytes per 512-bit block
//   BLOCK_WORDS - 32-bit schedule words per block
//   LEN_OFFSET  - byte offset of the 64-bit length field in the final block
package sha256_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFill,
      StPad,
      StXpad,
      StSend,
      StWait
   } state_e;

   localparam logic [7:0]  PAD_BYTE    = 8'h80;
   localparam int unsigned BLOCK_BYTES = 64;
   localparam int unsigned BLOCK_WORDS = 16;
   localparam int unsigned LEN_OFFSET  = 56;

   // A short beat is only allowed as the closing beat of a message.
   function automatic logic beat_legal(input logic [2:0] bytes, input logic last);
      return (bytes == 3'd4) || ((bytes < 3'd4) && last);
   endfunction

endpackage

// File: rtl/sha_msg_ctrl_if.sv
// sha_msg_ctrl_if: host message stream, SHA core word stream and status.
//   msg_*     - host beats in (valid/ready, 32-bit big-endian data, byte count, last)
//   blk_*     - schedule words out to the core (valid/ready, word, first/last markers)
//   core_done - core finished compressing a block
//   busy, err - controller status
// Modports: slave = controller view, master = host/core view.
interface sha_msg_ctrl_if;

   logic        msg_valid;
   logic        msg_ready;
   logic [31:0] msg_data;
   logic [2:0]  msg_bytes;
   logic        msg_last;
   logic        blk_valid;
   logic        blk_ready;
   logic [31:0] blk_word;
   logic        blk_first;
   logic        blk_last;
   logic        core_done;
   logic        busy;
   logic        err;

   modport slave (
      input  msg_valid, msg_data, msg_bytes, msg_last, blk_ready, core_done,
      output msg_ready, blk_valid, blk_word, blk_first, blk_last, busy, err
   );

   modport master (
      output msg_valid, msg_data, msg_bytes, msg_last, blk_ready, core_done,
      input  msg_ready, blk_valid, blk_word, blk_first, blk_last, busy, err
   );

endinterface

// File: rtl/sha_blk_buf.sv
// sha_blk_buf: 64-byte block buffer.
//   clk, rst        - clock, async active-low reset (clears buffer)
//   clr_i           - zero the whole buffer
//   wr_*            - write wr_bytes_i (0..4) MSB-first bytes of wr_data_i at wr_off_i
//   pad_*           - zero bytes from pad_off_i upward, PAD_BYTE at pad_off_i if pad80_i
//   len_en_i, len_i - write len_i big-endian into bytes LEN_OFFSET..63
//   rd_idx_i        - word index, rd_word_o = bytes 4*idx..4*idx+3 big-endian
module sha_blk_buf
   import sha256_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        wr_en_i,
   input  logic [6:0]  wr_off_i,
   input  logic [2:0]  wr_bytes_i,
   input  logic [31:0] wr_data_i,
   input  logic        pad_en_i,
   input  logic [6:0]  pad_off_i,
   input  logic        pad80_i,
   input  logic        len_en_i,
   input  logic [63:0] len_i,
   input  logic [3:0]  rd_idx_i,
   output logic [31:0] rd_word_o
);

   logic [7:0] mem_q [BLOCK_BYTES];
   logic [7:0] mem_d [BLOCK_BYTES];
   int         k;

   // Later operations take priority per byte: clear < data < pad < length.
   always_comb begin
      k = 0;
      for (int i = 0; i < int'(BLOCK_BYTES); i++) begin
         mem_d[i] = clr_i ? 8'h00 : mem_q[i];
         k = i - int'(wr_off_i);
         if (wr_en_i && (k >= 0) && (k < int'(wr_bytes_i))) begin
            mem_d[i] = 8'(wr_data_i >> (8 * (3 - (k & 3))));
         end
         if (pad_en_i && (i >= int'(pad_off_i))) begin
            mem_d[i] = ((i == int'(pad_off_i)) && pad80_i) ? PAD_BYTE : 8'h00;
         end
         if (len_en_i && (i >= int'(LEN_OFFSET))) begin
            mem_d[i] = 8'(len_i >> (8 * (7 - ((i - int'(LEN_OFFSET)) & 7))));
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(BLOCK_BYTES); i++) mem_q[i] <= 8'h00;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_word_o = {mem_q[{rd_idx_i, 2'd0}], mem_q[{rd_idx_i, 2'd1}],
                       mem_q[{rd_idx_i, 2'd2}], mem_q[{rd_idx_i, 2'd3}]};

endmodule

// File: rtl/sha_msg_ctrl.sv
// sha_msg_ctrl: packs host message beats into 512-bit blocks, applies SHA-256
// padding and length, and streams each block as 16 schedule words to the core.
//   clk, rst  - clock, async active-low reset
//   bus       - sha_msg_ctrl_if.slave (host beats, core words, core_done, busy, err)
//   WAIT_DONE - 1: hold after each block until core_done; 0: continue immediately
module sha_msg_ctrl
   import sha256_pkg::*;
#(
   parameter int unsigned WAIT_DONE = 1
) (
   input logic           clk,
   input logic           rst,
   sha_msg_ctrl_if.slave bus
);

   state_e      state_q, state_d;
   logic [6:0]  wptr_q, wptr_d;
   logic [3:0]  t_q, t_d;
   logic [63:0] cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        first_pend_q, first_pend_d;
   logic        final_q, final_d;
   logic        xpad_q, xpad_d;
   logic        pad80_q, pad80_d;
   logic        msg_ready_q, msg_ready_d;
   logic        blk_valid_q, blk_valid_d;
   logic        busy_q, busy_d;

   logic        blk_done;
   logic        buf_clr, buf_wr, buf_pad, buf_pad80, buf_len;
   logic [6:0]  buf_pad_off;
   logic [31:0] rd_word;

   always_comb begin
      state_d      = state_q;
      wptr_d       = wptr_q;
      t_d          = t_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      first_pend_d = first_pend_q;
      final_d      = final_q;
      xpad_d       = xpad_q;
      pad80_d      = pad80_q;
      blk_done     = 1'b0;
      buf_clr      = 1'b0;
      buf_wr       = 1'b0;
      buf_pad      = 1'b0;
      buf_pad80    = 1'b0;
      buf_len      = 1'b0;
      buf_pad_off  = 7'd0;

      unique case (state_q)
         StIdle, StFill: begin
            if (bus.msg_valid && msg_ready_q) begin
               if (state_q == StIdle) begin
                  cnt_d        = 64'd0;
                  err_d        = 1'b0;
                  first_pend_d = 1'b1;
               end
               if (!beat_legal(bus.msg_bytes, bus.msg_last)) begin
                  err_d = 1'b1;
               end else begin
                  buf_wr = 1'b1;
                  cnt_d  = cnt_d + {58'd0, bus.msg_bytes, 3'd0};
                  wptr_d = wptr_q + {4'd0, bus.msg_bytes};
                  if (bus.msg_last) begin
                     state_d = StPad;
                  end else if (wptr_d == 7'(BLOCK_BYTES)) begin
                     state_d = StSend;
                  end else begin
                     state_d = StFill;
                  end
               end
            end
         end
         StPad: begin
            // With n == 64 the pad offset lies past the buffer and the data stays intact.
            buf_pad     = 1'b1;
            buf_pad_off = wptr_q;
            buf_pad80   = 1'b1;
            if (wptr_q <= 7'(LEN_OFFSET - 1)) begin
               buf_len = 1'b1;
               final_d = 1'b1;
            end else begin
               xpad_d  = 1'b1;
               pad80_d = (wptr_q == 7'(BLOCK_BYTES));
            end
            state_d = StSend;
         end
         StXpad: begin
            buf_pad     = 1'b1;
            buf_pad_off = 7'd0;
            buf_pad80   = pad80_q;
            buf_len     = 1'b1;
            final_d     = 1'b1;
            xpad_d      = 1'b0;
            pad80_d     = 1'b0;
            state_d     = StSend;
         end
         StSend: begin
            if (blk_valid_q && bus.blk_ready) begin
               if (t_q == 4'd0) first_pend_d = 1'b0;
               t_d = t_q + 4'd1;
               if (t_q == 4'(BLOCK_WORDS - 1)) begin
                  if (WAIT_DONE != 0) state_d = StWait;
                  else                blk_done = 1'b1;
               end
            end
         end
         StWait: begin
            if (bus.core_done) blk_done = 1'b1;
         end
         default: state_d = StIdle;
      endcase

      if (blk_done) begin
         if (xpad_q) begin
            state_d = StXpad;
         end else if (final_q) begin
            state_d = StIdle;
            buf_clr = 1'b1;
            final_d = 1'b0;
            wptr_d  = 7'd0;
         end else begin
            state_d = StFill;
            wptr_d  = 7'd0;
         end
      end

      msg_ready_d = (state_d == StIdle) || (state_d == StFill);
      blk_valid_d = (state_d == StSend);
      busy_d      = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         wptr_q       <= 7'd0;
         t_q          <= 4'd0;
         cnt_q        <= 64'd0;
         err_q        <= 1'b0;
         first_pend_q <= 1'b0;
         final_q      <= 1'b0;
         xpad_q       <= 1'b0;
         pad80_q      <= 1'b0;
         msg_ready_q  <= 1'b0;
         blk_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wptr_q       <= wptr_d;
         t_q          <= t_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         first_pend_q <= first_pend_d;
         final_q      <= final_d;
         xpad_q       <= xpad_d;
         pad80_q      <= pad80_d;
         msg_ready_q  <= msg_ready_d;
         blk_valid_q  <= blk_valid_d;
         busy_q       <= busy_d;
      end
   end

   sha_blk_buf u_buf (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (buf_clr),
      .wr_en_i    (buf_wr),
      .wr_off_i   (wptr_q),
      .wr_bytes_i (bus.msg_bytes),
      .wr_data_i  (bus.msg_data),
      .pad_en_i   (buf_pad),
      .pad_off_i  (buf_pad_off),
      .pad80_i    (buf_pad80),
      .len_en_i   (buf_len),
      .len_i      (cnt_q),
      .rd_idx_i   (t_q),
      .rd_word_o  (rd_word)
   );

   // Word outputs are derived only from registers, so they hold while blk_ready is low.
   assign bus.msg_ready = msg_ready_q;
   assign bus.blk_valid = blk_valid_q;
   assign bus.blk_word  = blk_valid_q ? rd_word : 32'd0;
   assign bus.blk_first = blk_valid_q && first_pend_q && (t_q == 4'd0);
   assign bus.blk_last  = blk_valid_q && final_q && (t_q == 4'(BLOCK_WORDS - 1));
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_sha_msg_ctrl.sv
// tb_sha_msg_ctrl: randomized bench for sha_msg_ctrl against a SHA-256 padding model.
module tb_sha_msg_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sha_msg_ctrl_if bus ();

   sha_msg_ctrl #(.WAIT_DONE(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] w;
      logic        f;
      logic        l;
   } exp_t;

   int         checks = 0;
   int         errors = 0;
   exp_t       exp_q[$];
   logic [7:0] msg_q[$];

   task automatic make_msg(input int len);
      msg_q.delete();
      repeat (len) msg_q.push_back(8'($urandom));
   endtask

   // Standard SHA-256 padding of msg_q, split into 32-bit big-endian words.
   task automatic model();
      logic [7:0]  p[$];
      logic [63:0] bits;
      exp_t        e;
      p = msg_q;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bits = 64'(msg_q.size()) * 64'd8;
      for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
      exp_q.delete();
      for (int w = 0; w < p.size() / 4; w++) begin
         e.w = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
         e.f = (w == 0);
         e.l = (w == p.size() / 4 - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic quiet_inputs();
      bus.msg_valid = 1'b0;
      bus.msg_data  = 32'd0;
      bus.msg_bytes = 3'd0;
      bus.msg_last  = 1'b0;
      bus.blk_ready = 1'b0;
      bus.core_done = 1'b0;
   endtask

   // ready_mode: 0 always ready, 1 random, 2 stall 3 cycles at word 5.
   // inj_at: insert an illegal beat before that beat index (-1 none).
   // stop_at: leave after that many words accepted (-1 run to completion).
   task automatic run_msg(input int ready_mode, input bit pulse_fill, input int inj_at,
                          input int stop_at);
      int          nbeats, beat_idx, words_got, cyc, done_cnt, stall, len, nb;
      bit          inj_done, chk_err;
      logic [31:0] d;
      len       = msg_q.size();
      nbeats    = (len == 0) ? 1 : (len + 3) / 4;
      beat_idx  = 0;
      words_got = 0;
      cyc       = 0;
      done_cnt  = 0;
      stall     = 0;
      inj_done  = 1'b0;
      chk_err   = 1'b0;
      while ((words_got < exp_q.size() || done_cnt > 0 || bus.core_done) && cyc < 4000) begin
         @(negedge clk);
         if (stop_at >= 0 && words_got >= stop_at) break;
         if (inj_at == beat_idx && !inj_done) begin
            bus.msg_valid = 1'b1;
            bus.msg_data  = $urandom;
            bus.msg_bytes = 3'd2;
            bus.msg_last  = 1'b0;
         end else if (beat_idx < nbeats) begin
            nb = (beat_idx == nbeats - 1) ? len - 4 * beat_idx : 4;
            d  = $urandom;
            for (int j = 0; j < nb; j++) d[31-8*j -: 8] = msg_q[4*beat_idx+j];
            bus.msg_valid = 1'b1;
            bus.msg_data  = d;
            bus.msg_bytes = 3'(nb);
            bus.msg_last  = (beat_idx == nbeats - 1);
         end else begin
            bus.msg_valid = 1'b0;
            bus.msg_bytes = 3'd0;
            bus.msg_last  = 1'b0;
         end
         if (done_cnt > 0) begin
            done_cnt--;
            bus.core_done = (done_cnt == 0);
         end else begin
            // Spurious pulses while filling must be ignored.
            bus.core_done = pulse_fill && bus.msg_ready && bus.busy && ($urandom_range(0, 1) == 1);
         end
         case (ready_mode)
            1:       bus.blk_ready = ($urandom_range(0, 2) != 0);
            2: begin
               bus.blk_ready = !(words_got == 5 && bus.blk_valid && stall < 3);
               if (!bus.blk_ready) stall++;
            end
            default: bus.blk_ready = 1'b1;
         endcase
         #1;
         if (chk_err) begin
            checks++;
            if (bus.err !== 1'b1) begin
               errors++;
               $display("FAIL err_after_illegal got %b want 1", bus.err);
            end
            chk_err = 1'b0;
         end
         if (bus.msg_valid && bus.msg_ready) begin
            if (inj_at == beat_idx && !inj_done) begin
               inj_done = 1'b1;
               chk_err  = 1'b1;
            end else begin
               beat_idx++;
            end
         end
         if (bus.blk_valid) begin
            checks++;
            if (words_got >= exp_q.size()) begin
               errors++;
               $display("FAIL extra_word got w=%h want no blk_valid", bus.blk_word);
            end else begin
               if ({bus.blk_word, bus.blk_first, bus.blk_last} !==
                   {exp_q[words_got].w, exp_q[words_got].f, exp_q[words_got].l}) begin
                  errors++;
                  $display("FAIL word[%0d] got w=%h f=%b l=%b want w=%h f=%b l=%b", words_got,
                           bus.blk_word, bus.blk_first, bus.blk_last, exp_q[words_got].w,
                           exp_q[words_got].f, exp_q[words_got].l);
               end
               if (bus.blk_ready) begin
                  words_got++;
                  if (words_got % 16 == 0) done_cnt = $urandom_range(1, 3);
               end
            end
         end
         cyc++;
      end
      if (stop_at < 0) begin
         checks++;
         if (words_got != exp_q.size() || bus.busy !== 1'b0 || bus.msg_ready !== 1'b1) begin
            errors++;
            $display("FAIL msg_complete got words=%0d busy=%b ready=%b want words=%0d busy=0 ready=1",
                     words_got, bus.busy, bus.msg_ready, exp_q.size());
         end
      end
   endtask

   task automatic test_reset();
      quiet_inputs();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bus.msg_ready, bus.blk_valid, bus.blk_word, bus.blk_first, bus.blk_last, bus.busy,
           bus.err} !== 38'd0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b v=%b w=%h busy=%b err=%b want all 0",
                  bus.msg_ready, bus.blk_valid, bus.blk_word, bus.busy, bus.err);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.msg_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge got %b want 0", bus.msg_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.msg_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL ready_after_edge got rdy=%b busy=%b want rdy=1 busy=0", bus.msg_ready,
                  bus.busy);
      end
   endtask

   task automatic test_abc();
      exp_t e;
      msg_q = '{8'h61, 8'h62, 8'h63};
      exp_q.delete();
      for (int w = 0; w < 16; w++) begin
         e.w = (w == 0) ? 32'h61626380 : (w == 15) ? 32'h00000018 : 32'h0;
         e.f = (w == 0);
         e.l = (w == 15);
         exp_q.push_back(e);
      end
      run_msg(0, 1'b0, -1, -1);
   endtask

   task automatic test_empty();
      exp_t e;
      msg_q.delete();
      exp_q.delete();
      for (int w = 0; w < 16; w++) begin
         e.w = (w == 0) ? 32'h80000000 : 32'h0;
         e.f = (w == 0);
         e.l = (w == 15);
         exp_q.push_back(e);
      end
      run_msg(0, 1'b0, -1, -1);
   endtask

   task automatic test_boundaries();
      int lens[4] = '{55, 56, 63, 64};
      foreach (lens[i]) begin
         make_msg(lens[i]);
         model();
         run_msg(i % 2, 1'b0, -1, -1);
      end
   endtask

   task automatic test_stall();
      make_msg(20);
      model();
      run_msg(2, 1'b1, -1, -1);
   endtask

   task automatic test_random();
      repeat (6) begin
         make_msg($urandom_range(0, 150));
         model();
         run_msg(1, 1'b1, -1, -1);
      end
   endtask

   task automatic test_illegal();
      make_msg(30);
      model();
      run_msg(1, 1'b0, 2, -1);
      checks++;
      if (bus.err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky got %b want 1", bus.err);
      end
   endtask

   task automatic test_reset_mid();
      bit seen_valid;
      make_msg(64);
      model();
      run_msg(0, 1'b0, 5, 3);
      quiet_inputs();
      checks++;
      if (bus.blk_valid !== 1'b1 || bus.err !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset got v=%b err=%b want v=1 err=1", bus.blk_valid, bus.err);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.msg_ready, bus.blk_valid, bus.blk_word, bus.blk_first, bus.blk_last, bus.busy,
           bus.err} !== 38'd0) begin
         errors++;
         $display("FAIL mid_reset got rdy=%b v=%b w=%h busy=%b err=%b want all 0",
                  bus.msg_ready, bus.blk_valid, bus.blk_word, bus.busy, bus.err);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      seen_valid = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.blk_valid !== 1'b0) seen_valid = 1'b1;
      end
      checks++;
      if (seen_valid || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle got valid_seen=%b busy=%b want 0 0", seen_valid, bus.busy);
      end
      make_msg(10);
      model();
      run_msg(0, 1'b0, -1, -1);
      checks++;
      if (bus.err !== 1'b0) begin
         errors++;
         $display("FAIL err_cleared got %b want 0", bus.err);
      end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_empty();
      test_boundaries();
      test_stall();
      test_random();
      test_illegal();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
